pipe_skid_stage: RTL and testbench

Parametrised pipeline stage register, the successor to fixed-field stall-enable stage registers such as the MEM/WB register.
- Carries NUM_CH data channels plus control fields between stages using a valid/ready handshake.
- Contains a 2-entry skid buffer, so upstream ready is driven from a register and never depends combinationally on out_ready.
- Provides flush-to-bubble, occupancy reporting, and two-operand forwarding hit detection against the held destination register.

---
 rtl/pipe_skid_stage.sv | 132 +++++++++++++
 tb/tb_pipe_skid_stage.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with a 2-entry skid buffer: upstream ready comes from
// registered state only, plus flush, occupancy and forwarding hit detection on the head.
module pipe_skid_stage #(
    parameter int DATA_W = 16,
    parameter int NUM_CH = 2,
    parameter int CTRL_W = 2,
    parameter int REG_W  = 4,
    parameter int FWD_CH = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_write,
    input  logic [REG_W-1:0]         in_rd,
    input  logic [CTRL_W-1:0]        in_ctrl,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_write,
    output logic [REG_W-1:0]         out_rd,
    output logic [CTRL_W-1:0]        out_ctrl,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [1:0]               count,
    input  logic [REG_W-1:0]         q_rs,
    input  logic [REG_W-1:0]         q_rt,
    output logic                     hit_rs,
    output logic                     hit_rt,
    output logic [DATA_W-1:0]        fwd_data
);

    logic              main_valid_reg, main_valid_next;
    logic              skid_valid_reg, skid_valid_next;
    logic              main_write_reg, skid_write_reg;
    logic [REG_W-1:0]  main_rd_reg, skid_rd_reg;
    logic [CTRL_W-1:0] main_ctrl_reg, skid_ctrl_reg;
    logic [DATA_W-1:0] main_data_reg [NUM_CH];
    logic [DATA_W-1:0] skid_data_reg [NUM_CH];

    logic in_fire, out_fire;
    logic load_main_in, load_main_skid, load_skid;

    assign in_ready  = !skid_valid_reg;
    assign in_fire   = in_valid & in_ready;
    assign out_valid = main_valid_reg;
    assign out_fire  = out_valid & out_ready;

    // When the skid is occupied the head is necessarily valid, so only the skid drains into it.
    always_comb begin
        main_valid_next = main_valid_reg;
        skid_valid_next = skid_valid_reg;
        load_main_in    = 1'b0;
        load_main_skid  = 1'b0;
        load_skid       = 1'b0;
        if (flush) begin
            main_valid_next = 1'b0;
            skid_valid_next = 1'b0;
        end else if (skid_valid_reg) begin
            if (out_fire) begin
                load_main_skid  = 1'b1;
                skid_valid_next = 1'b0;
            end
        end else if (!main_valid_reg || out_ready) begin
            load_main_in    = in_fire;
            main_valid_next = in_fire;
        end else if (in_fire) begin
            load_skid       = 1'b1;
            skid_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
            main_write_reg <= 1'b0;
            main_rd_reg    <= '0;
            main_ctrl_reg  <= '0;
            skid_write_reg <= 1'b0;
            skid_rd_reg    <= '0;
            skid_ctrl_reg  <= '0;
        end else begin
            main_valid_reg <= main_valid_next;
            skid_valid_reg <= skid_valid_next;
            if (load_main_in) begin
                main_write_reg <= in_write;
                main_rd_reg    <= in_rd;
                main_ctrl_reg  <= in_ctrl;
            end else if (load_main_skid) begin
                main_write_reg <= skid_write_reg;
                main_rd_reg    <= skid_rd_reg;
                main_ctrl_reg  <= skid_ctrl_reg;
            end
            if (load_skid) begin
                skid_write_reg <= in_write;
                skid_rd_reg    <= in_rd;
                skid_ctrl_reg  <= in_ctrl;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            always_ff @(posedge clk) begin
                if (rst) begin
                    main_data_reg[gi] <= '0;
                    skid_data_reg[gi] <= '0;
                end else begin
                    if (load_main_in)
                        main_data_reg[gi] <= in_data[gi*DATA_W +: DATA_W];
                    else if (load_main_skid)
                        main_data_reg[gi] <= skid_data_reg[gi];
                    if (load_skid)
                        skid_data_reg[gi] <= in_data[gi*DATA_W +: DATA_W];
                end
            end
            assign out_data[gi*DATA_W +: DATA_W] = main_data_reg[gi];
        end
    endgenerate

    assign out_write = main_valid_reg & main_write_reg;
    assign out_rd    = main_rd_reg;
    assign out_ctrl  = main_ctrl_reg;
    assign count     = 2'(main_valid_reg) + 2'(skid_valid_reg);

    // Only the head is older than the consumer; register 0 never forwards.
    assign hit_rs   = out_write & (out_rd == q_rs) & (q_rs != '0);
    assign hit_rt   = out_write & (out_rd == q_rt) & (q_rt != '0);
    assign fwd_data = main_data_reg[FWD_CH];

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed vector bench for pipe_skid_stage: default configuration plus a
// 3-channel 32-bit instance for channel packing and forwarding-channel selection.
module tb_pipe_skid_stage;

    typedef struct {
        logic        rst, flush, iv, w;
        logic [3:0]  rd;
        logic [1:0]  ctrl;
        logic [31:0] data;
        logic        ordy;
        logic [3:0]  qrs, qrt;
        logic        ov, ow;
        logic [3:0]  ord;
        logic [1:0]  octrl;
        logic [31:0] odata;
        logic [1:0]  cnt;
        logic        ir, hrs, hrt;
        logic [15:0] fwd;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // default-parameter DUT
    logic        rst = 1'b1, flush = 1'b0, in_valid = 1'b0, in_write = 1'b0, out_ready = 1'b0;
    logic [3:0]  in_rd = '0, q_rs = '0, q_rt = '0;
    logic [1:0]  in_ctrl = '0;
    logic [31:0] in_data = '0;
    logic        in_ready, out_valid, out_write, hit_rs, hit_rt;
    logic [3:0]  out_rd;
    logic [1:0]  out_ctrl, count;
    logic [31:0] out_data;
    logic [15:0] fwd_data;

    pipe_skid_stage dut_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_write(in_write),
        .in_rd(in_rd), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_write(out_write),
        .out_rd(out_rd), .out_ctrl(out_ctrl), .out_data(out_data), .count(count),
        .q_rs(q_rs), .q_rt(q_rt), .hit_rs(hit_rs), .hit_rt(hit_rt), .fwd_data(fwd_data)
    );

    // wide instance
    logic        b_rst = 1'b1, b_flush = 1'b0, b_in_valid = 1'b0, b_in_write = 1'b0, b_out_ready = 1'b0;
    logic [3:0]  b_in_rd = '0, b_q_rs = '0, b_q_rt = '0;
    logic [1:0]  b_in_ctrl = '0;
    logic [95:0] b_in_data = '0;
    logic        b_in_ready, b_out_valid, b_out_write, b_hit_rs, b_hit_rt;
    logic [3:0]  b_out_rd;
    logic [1:0]  b_out_ctrl, b_count;
    logic [95:0] b_out_data;
    logic [31:0] b_fwd_data;

    pipe_skid_stage #(.DATA_W(32), .NUM_CH(3), .CTRL_W(2), .REG_W(4), .FWD_CH(2)) dut_b (
        .clk(clk), .rst(b_rst), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_write(b_in_write),
        .in_rd(b_in_rd), .in_ctrl(b_in_ctrl), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_write(b_out_write),
        .out_rd(b_out_rd), .out_ctrl(b_out_ctrl), .out_data(b_out_data), .count(b_count),
        .q_rs(b_q_rs), .q_rt(b_q_rt), .hit_rs(b_hit_rs), .hit_rt(b_hit_rt), .fwd_data(b_fwd_data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, f, iv, w, input logic [3:0] rd, input logic [1:0] ctrl,
                       input logic [31:0] data, input logic ordy, input logic [3:0] qrs, qrt,
                       input logic ov, ow, input logic [3:0] ord, input logic [1:0] octrl,
                       input logic [31:0] odata, input logic [1:0] cnt,
                       input logic ir, hrs, hrt, input logic [15:0] fwd);
        vec_t v;
        v.rst = r; v.flush = f; v.iv = iv; v.w = w; v.rd = rd; v.ctrl = ctrl; v.data = data;
        v.ordy = ordy; v.qrs = qrs; v.qrt = qrt; v.ov = ov; v.ow = ow; v.ord = ord;
        v.octrl = octrl; v.odata = odata; v.cnt = cnt; v.ir = ir; v.hrs = hrs; v.hrt = hrt;
        v.fwd = fwd;
        vecs.push_back(v);
    endtask

    // drive at negedge, sample 1 time unit after the following posedge
    task automatic step_a(input logic iv, w, input logic [3:0] rd, input logic [31:0] data,
                          input logic ordy);
        @(negedge clk);
        rst = 1'b0; flush = 1'b0; in_valid = iv; in_write = w; in_rd = rd; in_ctrl = '0;
        in_data = data; out_ready = ordy; q_rs = '0; q_rt = '0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //   rst f iv w rd  ct data          or qs qt | ov ow ord oc odata         cn ir hs ht fwd
        add(1, 0, 1, 1, 3,  1, 32'h1111AAAA, 1, 0, 0,   0, 0, 0,  0, 32'h0,        0, 1, 0, 0, 16'h0);
        add(1, 0, 1, 1, 3,  1, 32'h1111AAAA, 1, 0, 0,   0, 0, 0,  0, 32'h0,        0, 1, 0, 0, 16'h0);
        add(0, 0, 1, 1, 3,  1, 32'h1111AAAA, 1, 0, 0,   1, 1, 3,  1, 32'h1111AAAA, 1, 1, 0, 0, 16'hAAAA);
        add(0, 0, 1, 1, 4,  2, 32'h2222BBBB, 1, 0, 0,   1, 1, 4,  2, 32'h2222BBBB, 1, 1, 0, 0, 16'hBBBB);
        add(0, 0, 1, 1, 5,  3, 32'h3333CCCC, 1, 0, 0,   1, 1, 5,  3, 32'h3333CCCC, 1, 1, 0, 0, 16'hCCCC);
        add(0, 0, 0, 0, 0,  0, 32'h0,        1, 0, 0,   0, 0, 5,  3, 32'h3333CCCC, 0, 1, 0, 0, 16'hCCCC);
        add(0, 0, 1, 1, 6,  0, 32'h66660006, 0, 0, 0,   1, 1, 6,  0, 32'h66660006, 1, 1, 0, 0, 16'h0006);
        add(0, 0, 1, 1, 7,  0, 32'h77770007, 0, 0, 0,   1, 1, 6,  0, 32'h66660006, 2, 0, 0, 0, 16'h0006);
        add(0, 0, 1, 1, 8,  0, 32'h88880008, 0, 0, 0,   1, 1, 6,  0, 32'h66660006, 2, 0, 0, 0, 16'h0006);
        add(0, 0, 1, 1, 8,  0, 32'h88880008, 1, 0, 0,   1, 1, 7,  0, 32'h77770007, 1, 1, 0, 0, 16'h0007);
        add(0, 0, 0, 0, 0,  0, 32'h0,        1, 0, 0,   0, 0, 7,  0, 32'h77770007, 0, 1, 0, 0, 16'h0007);
        add(0, 0, 1, 1, 10, 1, 32'hAAAA000A, 0, 0, 0,   1, 1, 10, 1, 32'hAAAA000A, 1, 1, 0, 0, 16'h000A);
        add(0, 0, 1, 1, 11, 2, 32'hBBBB000B, 0, 0, 0,   1, 1, 10, 1, 32'hAAAA000A, 2, 0, 0, 0, 16'h000A);
        add(0, 1, 1, 1, 9,  3, 32'h99990009, 0, 0, 0,   0, 0, 10, 1, 32'hAAAA000A, 0, 1, 0, 0, 16'h000A);
        add(0, 0, 0, 0, 0,  0, 32'h0,        1, 0, 0,   0, 0, 10, 1, 32'hAAAA000A, 0, 1, 0, 0, 16'h000A);
        add(0, 1, 1, 1, 9,  3, 32'h99990009, 1, 0, 0,   0, 0, 10, 1, 32'hAAAA000A, 0, 1, 0, 0, 16'h000A);
        add(0, 0, 1, 1, 5,  0, 32'h000000F0, 0, 5, 2,   1, 1, 5,  0, 32'h000000F0, 1, 1, 1, 0, 16'h00F0);
        add(0, 0, 0, 0, 0,  0, 32'h0,        0, 2, 5,   1, 1, 5,  0, 32'h000000F0, 1, 1, 0, 1, 16'h00F0);
        add(0, 0, 0, 0, 0,  0, 32'h0,        1, 5, 5,   0, 0, 5,  0, 32'h000000F0, 0, 1, 0, 0, 16'h00F0);
        add(0, 0, 1, 0, 5,  0, 32'h000000F0, 0, 5, 5,   1, 0, 5,  0, 32'h000000F0, 1, 1, 0, 0, 16'h00F0);
        add(0, 0, 0, 0, 0,  0, 32'h0,        1, 5, 5,   0, 0, 5,  0, 32'h000000F0, 0, 1, 0, 0, 16'h00F0);
        add(0, 0, 1, 1, 0,  0, 32'h00000123, 0, 0, 0,   1, 1, 0,  0, 32'h00000123, 1, 1, 0, 0, 16'h0123);
        add(0, 0, 0, 0, 0,  0, 32'h0,        0, 0, 1,   1, 1, 0,  0, 32'h00000123, 1, 1, 0, 0, 16'h0123);
        add(0, 0, 1, 1, 2,  3, 32'h00000222, 0, 0, 0,   1, 1, 0,  0, 32'h00000123, 2, 0, 0, 0, 16'h0123);
        add(1, 0, 1, 1, 2,  3, 32'h00000222, 0, 0, 0,   0, 0, 0,  0, 32'h0,        0, 1, 0, 0, 16'h0);
        add(0, 0, 1, 1, 1,  2, 32'h12345678, 1, 0, 0,   1, 1, 1,  2, 32'h12345678, 1, 1, 0, 0, 16'h5678);
        add(0, 0, 0, 0, 0,  0, 32'h0,        1, 0, 0,   0, 0, 1,  2, 32'h12345678, 0, 1, 0, 0, 16'h5678);

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            v = vecs[i];
            @(negedge clk);
            rst = v.rst; flush = v.flush; in_valid = v.iv; in_write = v.w; in_rd = v.rd;
            in_ctrl = v.ctrl; in_data = v.data; out_ready = v.ordy; q_rs = v.qrs; q_rt = v.qrt;
            @(posedge clk);
            #1;
            $display("vec %0d: out_valid=%0b rd=%0d data=%h count=%0d in_ready=%0b hit=%0b%0b",
                     i, out_valid, out_rd, out_data, count, in_ready, hit_rs, hit_rt);
            chk($sformatf("v%0d.out_valid", i), 32'(out_valid), 32'(v.ov));
            chk($sformatf("v%0d.out_write", i), 32'(out_write), 32'(v.ow));
            chk($sformatf("v%0d.out_rd", i),    32'(out_rd),    32'(v.ord));
            chk($sformatf("v%0d.out_ctrl", i),  32'(out_ctrl),  32'(v.octrl));
            chk($sformatf("v%0d.out_data", i),  out_data,       v.odata);
            chk($sformatf("v%0d.count", i),     32'(count),     32'(v.cnt));
            chk($sformatf("v%0d.in_ready", i),  32'(in_ready),  32'(v.ir));
            chk($sformatf("v%0d.hit_rs", i),    32'(hit_rs),    32'(v.hrs));
            chk($sformatf("v%0d.hit_rt", i),    32'(hit_rt),    32'(v.hrt));
            chk($sformatf("v%0d.fwd_data", i),  32'(fwd_data),  32'(v.fwd));
        end

        // Output stability under sustained backpressure, then in-order drain.
        step_a(1, 1, 12, 32'h0000C00C, 0);
        chk("hold.first_rd", 32'(out_rd), 32'd12);
        step_a(1, 1, 13, 32'h0000D00D, 0);
        chk("hold.count_full", 32'(count), 32'd2);
        for (int k = 0; k < 3; k++) begin
            step_a(1, 1, 14, 32'h0000E00E, 0);
            $display("hold %0d: out_rd=%0d out_data=%h in_ready=%0b", k, out_rd, out_data, in_ready);
            chk($sformatf("hold%0d.out_rd", k),   32'(out_rd), 32'd12);
            chk($sformatf("hold%0d.out_data", k), out_data,    32'h0000C00C);
            chk($sformatf("hold%0d.in_ready", k), 32'(in_ready), 32'd0);
        end
        step_a(0, 0, 0, 32'h0, 1);
        chk("drain.second_rd",   32'(out_rd), 32'd13);
        chk("drain.second_data", out_data,    32'h0000D00D);
        chk("drain.count",       32'(count),  32'd1);
        step_a(0, 0, 0, 32'h0, 1);
        chk("drain.empty_valid", 32'(out_valid), 32'd0);
        chk("drain.empty_count", 32'(count),      32'd0);

        // Wide instance: reset state, channel packing, forwarding channel select.
        @(negedge clk);
        chk("wide.rst_data_lo", b_out_data[31:0],  32'h0);
        chk("wide.rst_data_hi", b_out_data[95:64], 32'h0);
        chk("wide.rst_count",   32'(b_count),      32'd0);
        b_rst = 1'b0; b_in_valid = 1'b1; b_in_write = 1'b1; b_in_rd = 4'd7; b_in_ctrl = 2'd1;
        b_in_data = {32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000}; b_out_ready = 1'b0;
        b_q_rs = 4'd7; b_q_rt = 4'd3;
        @(posedge clk);
        #1;
        $display("wide: out_valid=%0b out_data=%h fwd_data=%h", b_out_valid, b_out_data, b_fwd_data);
        chk("wide.out_valid", 32'(b_out_valid), 32'd1);
        chk("wide.ch0",       b_out_data[31:0],  32'hAAAA0000);
        chk("wide.ch1",       b_out_data[63:32], 32'hBBBB0001);
        chk("wide.ch2",       b_out_data[95:64], 32'hCCCC0002);
        chk("wide.fwd_data",  b_fwd_data,        32'hCCCC0002);
        chk("wide.hit_rs",    32'(b_hit_rs),     32'd1);
        chk("wide.hit_rt",    32'(b_hit_rt),     32'd0);
        @(negedge clk);
        b_in_valid = 1'b0; b_out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("wide.drain_valid", 32'(b_out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
